// File: rtl/sensemi_tscap_pkg.sv
// sensemi_tscap_pkg
// Shared definitions for the timestamp capture block:
//   - default parameter constants for the top level
//   - edge_sel_e, the per-channel edge-select encoding (used only when the
//     optional edge-select feature is built in)
//   - level_width(): width of a FIFO fill-level field able to hold 0..depth
//   - sel_width():   width of a channel-select field, never below 1 bit
package sensemi_tscap_pkg;

   localparam int DEF_TS_WIDTH   = 48;
   localparam int DEF_NUM_CH     = 4;
   localparam int DEF_FIFO_DEPTH = 8;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'b00,
      EDGE_FALL = 2'b01,
      EDGE_BOTH = 2'b10,
      EDGE_NONE = 2'b11
   } edge_sel_e;

   // A FIFO of depth D can hold 0..D entries, so it needs D+1 distinct codes.
   function automatic int level_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // A single-channel build still gets a 1-bit select port.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sensemi_ts_fifo.sv
// sensemi_ts_fifo
// Single-channel synchronous FIFO holding captured timestamps.
// Parameters:
//   WIDTH - entry width (timestamp width)
//   DEPTH - number of entries, power of two, 2..64
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   push        - write push_data (accepted if not full, or if a pop is
//                 accepted in the same cycle)
//   push_data   - entry to write
//   pop         - remove the head entry (ignored when empty)
//   head        - current head entry (valid when not empty)
//   level       - number of stored entries, 0..DEPTH
//   full, empty - status flags derived from level
module sensemi_ts_fifo
   import sensemi_tscap_pkg::*;
#(
   parameter int WIDTH = DEF_TS_WIDTH,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [WIDTH-1:0]              push_data,
   input  logic                          pop,
   output logic [WIDTH-1:0]              head,
   output logic [level_width(DEPTH)-1:0] level,
   output logic                          full,
   output logic                          empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = level_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full  = (level == LVL_W'(DEPTH));
   assign empty = (level == '0);
   assign head  = mem[rd_ptr];

   // A pop frees a slot in the same cycle, so a full FIFO can still take a
   // push when it is being popped at the same time.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Pointers wrap naturally because DEPTH is a power of two; level moves
   // only when exactly one of push/pop is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage is not reset; the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/sensemi_timestamp_capture.sv
// sensemi_timestamp_capture
// Free-running timestamp counter with NUM_CH event capture channels. Each
// event line is synchronised, edge-detected and, when enabled, the current
// counter value is queued in that channel's FIFO for later readout.
// Optional feature macro: SENSEMI_TSCAP_EDGE_SEL_EN adds i_edge_sel for
// per-channel edge selection; without it every channel captures rising edges.
// Ports:
//   axi_clk, aresetn - clock, asynchronous active-low reset
//   i_enable         - counter increments while high
//   i_ts_clear       - synchronous counter clear (wins over i_enable)
//   i_evt            - asynchronous event lines
//   i_ch_en          - per-channel capture enable
//   i_edge_sel       - 2 bits per channel: rise/fall/both/none (macro only)
//   i_pop, i_pop_ch  - read request and channel to read
//   o_rd_valid       - o_rd_data holds a popped entry this cycle
//   o_rd_data        - popped timestamp, held between pops
//   o_rd_err         - pop requested on an empty or nonexistent channel
//   o_ts, o_wrap     - live counter and one-cycle wrap pulse
//   o_level          - per-channel fill level
//   o_ovf, i_ovf_clr - sticky per-channel overflow flag and its clear
module sensemi_timestamp_capture
   import sensemi_tscap_pkg::*;
#(
   parameter int TS_WIDTH   = DEF_TS_WIDTH,
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                                       axi_clk,
   input  logic                                       aresetn,
   input  logic                                       i_enable,
   input  logic                                       i_ts_clear,
   input  logic [NUM_CH-1:0]                          i_evt,
   input  logic [NUM_CH-1:0]                          i_ch_en,
`ifdef SENSEMI_TSCAP_EDGE_SEL_EN
   input  logic [2*NUM_CH-1:0]                        i_edge_sel,
`endif
   input  logic                                       i_pop,
   input  logic [sel_width(NUM_CH)-1:0]               i_pop_ch,
   output logic                                       o_rd_valid,
   output logic [TS_WIDTH-1:0]                        o_rd_data,
   output logic                                       o_rd_err,
   output logic [TS_WIDTH-1:0]                        o_ts,
   output logic                                       o_wrap,
   output logic [NUM_CH*level_width(FIFO_DEPTH)-1:0]  o_level,
   output logic [NUM_CH-1:0]                          o_ovf,
   input  logic [NUM_CH-1:0]                          i_ovf_clr
);

   localparam int LVL_W = level_width(FIFO_DEPTH);
   localparam int SEL_W = sel_width(NUM_CH);

   logic [TS_WIDTH-1:0] ts;
   logic [NUM_CH-1:0]   sync1;
   logic [NUM_CH-1:0]   sync2;
   logic [NUM_CH-1:0]   sync3;
   logic [NUM_CH-1:0]   rise_q;
`ifdef SENSEMI_TSCAP_EDGE_SEL_EN
   logic [NUM_CH-1:0]   fall_q;
`endif
   logic [NUM_CH-1:0]   capture;
   logic [NUM_CH-1:0]   push_vec;
   logic [NUM_CH-1:0]   pop_vec;
   logic [NUM_CH-1:0]   full_vec;
   logic [NUM_CH-1:0]   empty_vec;
   logic [NUM_CH-1:0]   ovf_set;
   logic [TS_WIDTH-1:0] heads [NUM_CH];
   logic [TS_WIDTH-1:0] head_sel;
   logic                sel_empty;
   logic                pop_ok;

   assign o_ts = ts;

   // Timestamp counter. The wrap pulse is registered so it lines up with the
   // cycle in which o_ts reads 0 after rolling over; a clear never pulses it.
   always_ff @(posedge axi_clk or negedge aresetn) begin
      if (!aresetn) begin
         ts     <= '0;
         o_wrap <= 1'b0;
      end else begin
         o_wrap <= i_enable & ~i_ts_clear & (&ts);
         if (i_ts_clear) begin
            ts <= '0;
         end else if (i_enable) begin
            ts <= ts + TS_WIDTH'(1);
         end
      end
   end

   // Two synchroniser flops, a history flop, then a registered edge pulse.
   // An input edge therefore shows up as a detect pulse three cycles later,
   // and the pulse cycle's o_ts is what gets queued on the following edge.
`ifdef SENSEMI_TSCAP_EDGE_SEL_EN
   always_ff @(posedge axi_clk or negedge aresetn) begin
      if (!aresetn) begin
         sync1  <= '0;
         sync2  <= '0;
         sync3  <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         sync1  <= i_evt;
         sync2  <= sync1;
         sync3  <= sync2;
         rise_q <= sync2 & ~sync3;
         fall_q <= ~sync2 & sync3;
      end
   end

   // Per-channel edge selection applied to the registered edge pulses.
   always_comb begin
      capture = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         case (edge_sel_e'(i_edge_sel[2*c +: 2]))
            EDGE_RISE: capture[c] = rise_q[c];
            EDGE_FALL: capture[c] = fall_q[c];
            EDGE_BOTH: capture[c] = rise_q[c] | fall_q[c];
            default:   capture[c] = 1'b0;
         endcase
      end
   end
`else
   always_ff @(posedge axi_clk or negedge aresetn) begin
      if (!aresetn) begin
         sync1  <= '0;
         sync2  <= '0;
         sync3  <= '0;
         rise_q <= '0;
      end else begin
         sync1  <= i_evt;
         sync2  <= sync1;
         sync3  <= sync2;
         rise_q <= sync2 & ~sync3;
      end
   end

   // Without edge selection every channel captures rising edges only.
   always_comb begin
      capture = rise_q;
   end
`endif

   assign push_vec = capture & i_ch_en;

   // Read-side channel decode. A select value with no matching channel
   // leaves sel_empty high, so out-of-range reads fall into the error path.
   always_comb begin
      head_sel  = '0;
      sel_empty = 1'b1;
      pop_vec   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (i_pop_ch == SEL_W'(c)) begin
            head_sel   = heads[c];
            sel_empty  = empty_vec[c];
            pop_vec[c] = i_pop & ~empty_vec[c];
         end
      end
   end

   assign pop_ok = i_pop & ~sel_empty;

   // A push is lost only when the FIFO is full and is not being popped.
   assign ovf_set = push_vec & full_vec & ~pop_vec;

   // Read response and sticky overflow flags; a new overflow beats a clear.
   always_ff @(posedge axi_clk or negedge aresetn) begin
      if (!aresetn) begin
         o_rd_valid <= 1'b0;
         o_rd_err   <= 1'b0;
         o_rd_data  <= '0;
         o_ovf      <= '0;
      end else begin
         o_rd_valid <= pop_ok;
         o_rd_err   <= i_pop & sel_empty;
         if (pop_ok) begin
            o_rd_data <= head_sel;
         end
         o_ovf <= (o_ovf & ~i_ovf_clr) | ovf_set;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      sensemi_ts_fifo #(
         .WIDTH (TS_WIDTH),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk       (axi_clk),
         .rst_n     (aresetn),
         .push      (push_vec[g]),
         .push_data (ts),
         .pop       (pop_vec[g]),
         .head      (heads[g]),
         .level     (o_level[g*LVL_W +: LVL_W]),
         .full      (full_vec[g]),
         .empty     (empty_vec[g])
      );
   end

endmodule

// File: tb/tb_sensemi_timestamp_capture.sv
// tb_sensemi_timestamp_capture
// Directed bench for sensemi_timestamp_capture. A 16-bit, 4-channel,
// depth-8 instance carries the capture/FIFO scenarios; a second 8-bit
// instance is used for the counter wrap and clear scenario.
module tb_sensemi_timestamp_capture;

   logic        axi_clk;
   logic        aresetn;

   logic        i_enable;
   logic        i_ts_clear;
   logic [3:0]  i_evt;
   logic [3:0]  i_ch_en;
`ifdef SENSEMI_TSCAP_EDGE_SEL_EN
   logic [7:0]  i_edge_sel;
   logic [1:0]  edge_sel8;
`endif
   logic        i_pop;
   logic [1:0]  i_pop_ch;
   logic        o_rd_valid;
   logic [15:0] o_rd_data;
   logic        o_rd_err;
   logic [15:0] o_ts;
   logic        o_wrap;
   logic [15:0] o_level;
   logic [3:0]  o_ovf;
   logic [3:0]  i_ovf_clr;

   logic        en8;
   logic        clr8;
   logic        rd_valid8;
   logic [7:0]  rd_data8;
   logic        rd_err8;
   logic [7:0]  ts8;
   logic        wrap8;
   logic [1:0]  level8;
   logic        ovf8;

   int          checks;
   int          errors;
   logic [15:0] ts_model;
   logic [15:0] exp_q [$];
   logic [15:0] exp_val;
   logic [15:0] last_val;
   int          pop_ch_wide;

   sensemi_timestamp_capture #(
      .TS_WIDTH   (16),
      .NUM_CH     (4),
      .FIFO_DEPTH (8)
   ) u_dut (
      .axi_clk    (axi_clk),
      .aresetn    (aresetn),
      .i_enable   (i_enable),
      .i_ts_clear (i_ts_clear),
      .i_evt      (i_evt),
      .i_ch_en    (i_ch_en),
`ifdef SENSEMI_TSCAP_EDGE_SEL_EN
      .i_edge_sel (i_edge_sel),
`endif
      .i_pop      (i_pop),
      .i_pop_ch   (i_pop_ch),
      .o_rd_valid (o_rd_valid),
      .o_rd_data  (o_rd_data),
      .o_rd_err   (o_rd_err),
      .o_ts       (o_ts),
      .o_wrap     (o_wrap),
      .o_level    (o_level),
      .o_ovf      (o_ovf),
      .i_ovf_clr  (i_ovf_clr)
   );

   sensemi_timestamp_capture #(
      .TS_WIDTH   (8),
      .NUM_CH     (1),
      .FIFO_DEPTH (2)
   ) u_dut8 (
      .axi_clk    (axi_clk),
      .aresetn    (aresetn),
      .i_enable   (en8),
      .i_ts_clear (clr8),
      .i_evt      (1'b0),
      .i_ch_en    (1'b0),
`ifdef SENSEMI_TSCAP_EDGE_SEL_EN
      .i_edge_sel (edge_sel8),
`endif
      .i_pop      (1'b0),
      .i_pop_ch   (1'b0),
      .o_rd_valid (rd_valid8),
      .o_rd_data  (rd_data8),
      .o_rd_err   (rd_err8),
      .o_ts       (ts8),
      .o_wrap     (wrap8),
      .o_level    (level8),
      .o_ovf      (ovf8),
      .i_ovf_clr  (1'b0)
   );

   // 100 MHz-style clock, rising edges at 5, 15, 25 ...
   initial begin
      axi_clk = 1'b0;
      forever #5 axi_clk = ~axi_clk;
   end

   // Safety net so a stuck run still ends with a visible failure.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   // Advance n clock edges, keeping the bench's own copy of the 16-bit
   // counter in step, and leave time 1 unit after the last edge.
   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge axi_clk);
         if (aresetn) begin
            if (i_ts_clear) ts_model = '0;
            else if (i_enable) ts_model = ts_model + 16'd1;
         end
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      ts_model    = '0;
      last_val    = '0;
      pop_ch_wide = 5;
      aresetn     = 1'b0;
      i_enable    = 1'b0;
      i_ts_clear  = 1'b0;
      i_evt       = '0;
      i_ch_en     = '1;
      i_pop       = 1'b0;
      i_pop_ch    = '0;
      i_ovf_clr   = '0;
      en8         = 1'b0;
      clr8        = 1'b0;
`ifdef SENSEMI_TSCAP_EDGE_SEL_EN
      i_edge_sel  = '0;
      edge_sel8   = '0;
`endif
      $display("[TB] start");
      #12;

      // Reset values
      checkOutput("rst_ts",       o_ts,       0);
      checkOutput("rst_rd_valid", o_rd_valid, 0);
      checkOutput("rst_rd_err",   o_rd_err,   0);
      checkOutput("rst_rd_data",  o_rd_data,  0);
      checkOutput("rst_wrap",     o_wrap,     0);
      checkOutput("rst_level",    o_level,    0);
      checkOutput("rst_ovf",      o_ovf,      0);
      checkOutput("rst_dut8",     {rd_valid8, rd_err8, ovf8, level8, rd_data8, ts8, wrap8}, 0);
      aresetn = 1'b1;

      // 8-bit counter: 255, wrap to 0 with a single o_wrap pulse, then clear
      en8 = 1'b1;
      applyStimulus(255);
      checkOutput("cnt_255",      ts8,   255);
      checkOutput("cnt_nowrap",   wrap8, 0);
      applyStimulus(1);
      checkOutput("cnt_wrap_ts",  ts8,   0);
      checkOutput("cnt_wrap",     wrap8, 1);
      applyStimulus(1);
      checkOutput("cnt_after_ts", ts8,   1);
      checkOutput("cnt_wrap_end", wrap8, 0);
      applyStimulus(99);
      checkOutput("cnt_100",      ts8,   100);
      clr8 = 1'b1;
      applyStimulus(1);
      clr8 = 1'b0;
      checkOutput("clr_ts",       ts8,   0);
      checkOutput("clr_nowrap",   wrap8, 0);
      en8 = 1'b0;
      checkOutput("hold_ts",      o_ts,  0);

      // Capture on channel 1 while o_ts=1000 -> 1003 queued
      i_enable = 1'b1;
      applyStimulus(1000);
      checkOutput("cap_ts_1000",  o_ts, 1000);
      i_evt[1] = 1'b1;
      applyStimulus(3);
      checkOutput("cap_not_yet",  o_level[7:4], 0);
      applyStimulus(1);
      checkOutput("cap_level",    o_level[7:4], 1);
      i_pop    = 1'b1;
      i_pop_ch = 2'd1;
      applyStimulus(1);
      i_pop    = 1'b0;
      checkOutput("cap_rd_valid", o_rd_valid, 1);
      checkOutput("cap_rd_data",  o_rd_data,  1003);
      checkOutput("cap_rd_err",   o_rd_err,   0);
      checkOutput("cap_level0",   o_level[7:4], 0);
      applyStimulus(1);
      checkOutput("cap_valid_end", o_rd_valid, 0);
      checkOutput("cap_data_hold", o_rd_data,  1003);
      i_evt[1] = 1'b0;

      // Nine events on channel 0: eight kept, the ninth dropped
      for (int k = 0; k < 9; k++) begin
         if (k < 8) exp_q.push_back(ts_model + 16'd3);
         i_evt[0] = 1'b1;
         applyStimulus(2);
         i_evt[0] = 1'b0;
         applyStimulus(2);
      end
      checkOutput("ovf_level",    o_level, 16'h0008);
      checkOutput("ovf_flag",     o_ovf,   4'b0001);
      i_ovf_clr = 4'b0001;
      applyStimulus(1);
      i_ovf_clr = '0;
      checkOutput("ovf_cleared",  o_ovf,   0);

      // Overflow and clear in the same cycle: the set wins
      i_evt[0] = 1'b1;
      applyStimulus(3);
      i_ovf_clr = 4'b0001;
      applyStimulus(1);
      i_ovf_clr = '0;
      i_evt[0]  = 1'b0;
      checkOutput("ovf_set_wins", o_ovf,   4'b0001);
      checkOutput("ovf_level_8",  o_level[3:0], 8);
      i_ovf_clr = 4'b0001;
      applyStimulus(1);
      i_ovf_clr = '0;
      checkOutput("ovf_clr2",     o_ovf,   0);
      applyStimulus(3);

      // Push and pop together on a full FIFO
      exp_q.push_back(ts_model + 16'd3);
      i_evt[0] = 1'b1;
      applyStimulus(3);
      i_pop    = 1'b1;
      i_pop_ch = 2'd0;
      applyStimulus(1);
      i_pop    = 1'b0;
      i_evt[0] = 1'b0;
      exp_val  = exp_q.pop_front();
      checkOutput("full_rd_valid", o_rd_valid, 1);
      checkOutput("full_oldest",   o_rd_data,  exp_val);
      checkOutput("full_level",    o_level[3:0], 8);
      checkOutput("full_no_ovf",   o_ovf,      0);

      // Drain channel 0 and compare every entry in order
      i_pop    = 1'b1;
      i_pop_ch = 2'd0;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1);
         exp_val = exp_q.pop_front();
         checkOutput("drain_valid", o_rd_valid, 1);
         checkOutput("drain_data",  o_rd_data,  exp_val);
         last_val = exp_val;
      end
      i_pop = 1'b0;
      checkOutput("drain_level", o_level, 0);

      // Pop on empty channel 2
      i_pop    = 1'b1;
      i_pop_ch = 2'd2;
      applyStimulus(1);
      i_pop    = 1'b0;
      checkOutput("empty_err",       o_rd_err,   1);
      checkOutput("empty_valid",     o_rd_valid, 0);
      checkOutput("empty_data_hold", o_rd_data,  last_val);
      applyStimulus(1);
      checkOutput("empty_err_end",   o_rd_err,   0);

      // Channel 5 does not fit the 2-bit select; its low bits reach channel 1,
      // which is empty, so the read must report an error.
      i_pop    = 1'b1;
      i_pop_ch = pop_ch_wide[1:0];
      applyStimulus(1);
      i_pop    = 1'b0;
      checkOutput("range_err",   o_rd_err,   1);
      checkOutput("range_valid", o_rd_valid, 0);

      // Frozen counter, detection coinciding with a clear: pre-clear value kept
      i_enable = 1'b0;
      exp_val  = ts_model;
      i_evt[2] = 1'b1;
      applyStimulus(3);
      i_ts_clear = 1'b1;
      applyStimulus(1);
      i_ts_clear = 1'b0;
      checkOutput("frz_ts_cleared", o_ts,          ts_model);
      checkOutput("frz_level",      o_level[11:8], 1);
      i_pop    = 1'b1;
      i_pop_ch = 2'd2;
      applyStimulus(1);
      i_pop    = 1'b0;
      i_evt[2] = 1'b0;
      checkOutput("frz_data",       o_rd_data, exp_val);

      // Disabled channel ignores events
      i_ch_en[3] = 1'b0;
      i_evt[3]   = 1'b1;
      applyStimulus(5);
      checkOutput("chen_level", o_level[15:12], 0);
      i_evt[3]   = 1'b0;
      applyStimulus(4);
      i_ch_en[3] = 1'b1;

`ifdef SENSEMI_TSCAP_EDGE_SEL_EN
      // Edge select: falling only, then both edges, on channel 1
      i_enable   = 1'b1;
      i_edge_sel = 8'b0000_0100;
      i_evt[1]   = 1'b1;
      applyStimulus(4);
      checkOutput("esel_no_rise", o_level[7:4], 0);
      exp_val    = ts_model + 16'd3;
      i_evt[1]   = 1'b0;
      applyStimulus(4);
      checkOutput("esel_fall",    o_level[7:4], 1);
      i_edge_sel = 8'b0000_1000;
      i_evt[1]   = 1'b1;
      applyStimulus(4);
      i_evt[1]   = 1'b0;
      applyStimulus(4);
      checkOutput("esel_both",    o_level[7:4], 3);
      i_pop    = 1'b1;
      i_pop_ch = 2'd1;
      applyStimulus(1);
      i_pop    = 1'b0;
      checkOutput("esel_data",    o_rd_data, exp_val);
      i_edge_sel = '0;
`endif

      // Mid-operation reset discards queued entries
      i_enable = 1'b1;
      i_evt[0] = 1'b1;
      applyStimulus(4);
      checkOutput("mid_level_pre", o_level[3:0], 1);
      i_enable = 1'b0;
      aresetn  = 1'b0;
      #1;
      ts_model = '0;
      checkOutput("mid_level_rst", o_level, 0);
      checkOutput("mid_ts_rst",    o_ts,    0);
      applyStimulus(2);
      aresetn  = 1'b1;
      i_enable = 1'b1;
      applyStimulus(3);
      checkOutput("mid_no_cap",    o_level, 0);
      applyStimulus(1);
      checkOutput("mid_cap",       o_level[3:0], 1);
      i_pop    = 1'b1;
      i_pop_ch = 2'd0;
      applyStimulus(1);
      i_pop    = 1'b0;
      i_evt[0] = 1'b0;
      checkOutput("mid_data",      o_rd_data, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
